// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending column emulator.
package vend_pkg;

   localparam int DEF_NCOL    = 8;
   localparam int DEF_STOCK_W = 4;

   typedef enum logic [1:0] {
      PARK   = 2'd0,
      NOTCH1 = 2'd1,
      RIDGE  = 2'd2,
      NOTCH2 = 2'd3
   } pos_t;

   // The CAM switch reads 1 on the rest position and the ridge, 0 in either notch.
   function automatic logic cam_of(input pos_t p);
      return (p == PARK) || (p == RIDGE);
   endfunction

endpackage

// File: rtl/vend_column.sv
// One emulated vending column: cam rotation, stock counter and empty-vend flag.
module vend_column
   import vend_pkg::*;
#(
   parameter int HALF_PERIOD = 50000,
   parameter int STOCK_W     = DEF_STOCK_W,
   parameter int INIT_STOCK  = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               motor,
   input  logic               load,
   input  logic [STOCK_W-1:0] load_value,
   output logic               cam,
   output logic               soldout,
   output logic               empty_vend,
   output logic               vend_done
);

   localparam int CNT_W = $clog2(HALF_PERIOD);
   localparam logic [CNT_W-1:0]   SEG_LAST   = CNT_W'(HALF_PERIOD - 1);
   localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

   pos_t               pos;
   pos_t               pos_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [STOCK_W-1:0] stock;
   logic               seg_end;
   logic               complete;

   assign seg_end  = motor && (cnt == SEG_LAST);
   assign complete = seg_end && (pos == NOTCH2);
   // Combinational so the top-level total updates on the same edge as the stock.
   assign vend_done = complete && (stock != '0);
   assign soldout   = (stock == '0);

   always_comb begin
      pos_nxt = pos;
      if (seg_end) begin
         case (pos)
            PARK:    pos_nxt = NOTCH1;
            NOTCH1:  pos_nxt = RIDGE;
            RIDGE:   pos_nxt = NOTCH2;
            default: pos_nxt = PARK;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pos        <= PARK;
         cnt        <= '0;
         cam        <= 1'b1;
         stock      <= STOCK_INIT;
         empty_vend <= 1'b0;
      end else begin
         pos <= pos_nxt;
         cam <= cam_of(pos_nxt);
         // A stopped motor freezes the counter exactly where it is.
         if (seg_end)
            cnt <= '0;
         else if (motor)
            cnt <= cnt + 1'b1;
         // Restock takes priority over a coincident completion decrement.
         if (load)
            stock <= load_value;
         else if (complete && (stock != '0))
            stock <= stock - 1'b1;
         if (load)
            empty_vend <= 1'b0;
         else if (complete && (stock == '0))
            empty_vend <= 1'b1;
      end
   end

endmodule

// File: rtl/vend_column_emulator.sv
// Eight-column responder for the vending controller's motor/CAM/sold-out interface.
module vend_column_emulator
   import vend_pkg::*;
#(
   parameter int NCOL        = DEF_NCOL,
   parameter int HALF_PERIOD = 50000,
   parameter int STOCK_W     = DEF_STOCK_W,
   parameter int INIT_STOCK  = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NCOL-1:0]    motor,
   input  logic               load,
   input  logic [NCOL-1:0]    load_mask,
   input  logic [STOCK_W-1:0] load_value,
   output logic [NCOL-1:0]    cam,
   output logic [NCOL-1:0]    soldout,
   output logic [NCOL-1:0]    empty_vend,
   output logic               multi_motor,
   output logic [15:0]        vend_total
);

   logic [NCOL-1:0] vend_done;
   logic [15:0]     vend_inc;

   for (genvar i = 0; i < NCOL; i++) begin : g_col
      vend_column #(
         .HALF_PERIOD (HALF_PERIOD),
         .STOCK_W     (STOCK_W),
         .INIT_STOCK  (INIT_STOCK)
      ) u_col (
         .clock      (clock),
         .reset      (reset),
         .motor      (motor[i]),
         .load       (load && load_mask[i]),
         .load_value (load_value),
         .cam        (cam[i]),
         .soldout    (soldout[i]),
         .empty_vend (empty_vend[i]),
         .vend_done  (vend_done[i])
      );
   end

   // Several columns may finish on the same edge; add them all at once.
   always_comb begin
      vend_inc = '0;
      for (int i = 0; i < NCOL; i++)
         vend_inc = vend_inc + 16'(vend_done[i]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         multi_motor <= 1'b0;
         vend_total  <= '0;
      end else begin
         if ($countones(motor) > 1)
            multi_motor <= 1'b1;
         vend_total <= vend_total + vend_inc;
      end
   end

endmodule

// File: tb/tb_vend_column_emulator.sv
// Directed bench for vend_column_emulator with HALF_PERIOD=4, INIT_STOCK=5.
module tb_vend_column_emulator;

   localparam int NCOL = 8;
   localparam int HP   = 4;
   localparam int SW   = 4;

   logic            clock = 1'b0;
   logic            reset;
   logic [NCOL-1:0] motor;
   logic            load;
   logic [NCOL-1:0] load_mask;
   logic [SW-1:0]   load_value;
   logic [NCOL-1:0] cam;
   logic [NCOL-1:0] soldout;
   logic [NCOL-1:0] empty_vend;
   logic            multi_motor;
   logic [15:0]     vend_total;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  motor;
      logic        load;
      logic [7:0]  mask;
      logic [3:0]  value;
      logic [7:0]  cam;
      logic [7:0]  sold;
      logic [15:0] total;
   } vec_t;

   vec_t vecs[$];

   vend_column_emulator #(
      .NCOL        (NCOL),
      .HALF_PERIOD (HP),
      .STOCK_W     (SW),
      .INIT_STOCK  (5)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .motor       (motor),
      .load        (load),
      .load_mask   (load_mask),
      .load_value  (load_value),
      .cam         (cam),
      .soldout     (soldout),
      .empty_vend  (empty_vend),
      .multi_motor (multi_motor),
      .vend_total  (vend_total)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive at the falling edge, let one rising edge happen, return at the next falling edge.
   task automatic step(input logic [7:0] m, input logic ld, input logic [7:0] msk, input logic [3:0] val);
      motor      = m;
      load       = ld;
      load_mask  = msk;
      load_value = val;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic add_vec(input logic [7:0] m, input logic ld, input logic [7:0] msk,
                          input logic [3:0] val, input logic [7:0] c, input logic [7:0] s,
                          input logic [15:0] t);
      vec_t v;
      v.motor = m; v.load = ld; v.mask = msk; v.value = val;
      v.cam = c; v.sold = s; v.total = t;
      vecs.push_back(v);
   endtask

   initial begin
      // Full rotation of column 2 with motor held 16 cycles, then released.
      for (int i = 0; i < 3; i++)  add_vec(8'h04, 0, 8'h00, 0, 8'hFF, 8'h00, 16'd0);
      for (int i = 3; i < 7; i++)  add_vec(8'h04, 0, 8'h00, 0, 8'hFB, 8'h00, 16'd0);
      for (int i = 7; i < 11; i++) add_vec(8'h04, 0, 8'h00, 0, 8'hFF, 8'h00, 16'd0);
      for (int i = 11; i < 15; i++) add_vec(8'h04, 0, 8'h00, 0, 8'hFB, 8'h00, 16'd0);
      add_vec(8'h04, 0, 8'h00, 0, 8'hFF, 8'h00, 16'd1);
      add_vec(8'h00, 0, 8'h00, 0, 8'hFF, 8'h00, 16'd1);

      reset = 1'b1;
      motor = '0; load = 1'b0; load_mask = '0; load_value = '0;
      @(negedge clock);
      step(8'h00, 0, 8'h00, 0);
      step(8'h00, 0, 8'h00, 0);
      reset = 1'b0;

      // Reset state and idle stability
      check("rst_cam", cam, 8'hFF);
      check("rst_soldout", soldout, 8'h00);
      check("rst_total", vend_total, 16'd0);
      check("rst_empty", empty_vend, 8'h00);
      check("rst_multi", multi_motor, 1'b0);
      for (int i = 0; i < 100; i++) step(8'h00, 0, 8'h00, 0);
      check("idle_cam", cam, 8'hFF);
      check("idle_total", vend_total, 16'd0);
      check("idle_stock2", dut.g_col[2].u_col.stock, 4'd5);

      // Table-driven rotation
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].motor, vecs[i].load, vecs[i].mask, vecs[i].value);
         check($sformatf("rot%0d_cam", i), cam, vecs[i].cam);
         check($sformatf("rot%0d_sold", i), soldout, vecs[i].sold);
         check($sformatf("rot%0d_total", i), vend_total, vecs[i].total);
      end
      check("rot_stock2", dut.g_col[2].u_col.stock, 4'd4);

      // Motor paused mid-rotation
      for (int i = 0; i < 6; i++) step(8'h04, 0, 8'h00, 0);
      check("pause_start_cam", cam, 8'hFB);
      for (int i = 0; i < 10; i++) begin
         step(8'h00, 0, 8'h00, 0);
         check($sformatf("pause%0d_cam", i), cam, 8'hFB);
      end
      step(8'h04, 0, 8'h00, 0);
      check("resume0_cam", cam, 8'hFB);
      step(8'h04, 0, 8'h00, 0);
      check("resume1_cam", cam, 8'hFF);
      for (int i = 0; i < 7; i++) step(8'h04, 0, 8'h00, 0);
      check("resume8_cam", cam, 8'hFB);
      check("resume8_total", vend_total, 16'd1);
      step(8'h04, 0, 8'h00, 0);
      check("resume9_cam", cam, 8'hFF);
      check("resume9_total", vend_total, 16'd2);
      check("resume_stock2", dut.g_col[2].u_col.stock, 4'd3);
      step(8'h00, 0, 8'h00, 0);

      // Empty column vend and restock
      step(8'h00, 1, 8'h01, 4'd0);
      check("load0_sold", soldout, 8'h01);
      for (int i = 0; i < 16; i++) begin
         step(8'h01, 0, 8'h00, 0);
         check($sformatf("empty%0d_sold", i), soldout, 8'h01);
      end
      step(8'h00, 0, 8'h00, 0);
      check("empty_flag", empty_vend, 8'h01);
      check("empty_total", vend_total, 16'd2);
      check("empty_cam", cam, 8'hFF);
      step(8'h00, 1, 8'h01, 4'd3);
      check("reload_empty", empty_vend, 8'h00);
      check("reload_sold", soldout, 8'h00);
      check("reload_stock0", dut.g_col[0].u_col.stock, 4'd3);

      // Multi-motor detection is sticky until reset
      step(8'h06, 0, 8'h00, 0);
      check("multi_set", multi_motor, 1'b1);
      step(8'h00, 0, 8'h00, 0);
      check("multi_hold", multi_motor, 1'b1);
      reset = 1'b1;
      step(8'h00, 0, 8'h00, 0);
      reset = 1'b0;
      check("multi_rst", multi_motor, 1'b0);
      check("rst2_total", vend_total, 16'd0);
      check("rst2_cam", cam, 8'hFF);
      check("rst2_stock0", dut.g_col[0].u_col.stock, 4'd5);

      // Load coinciding with completion on column 3
      step(8'h00, 1, 8'h08, 4'd1);
      for (int i = 0; i < 15; i++) step(8'h08, 0, 8'h00, 0);
      check("coinc_pre_cam", cam, 8'hF7);
      step(8'h08, 1, 8'h08, 4'd7);
      check("coinc_cam", cam, 8'hFF);
      check("coinc_total", vend_total, 16'd1);
      check("coinc_stock3", dut.g_col[3].u_col.stock, 4'd7);
      check("coinc_empty", empty_vend, 8'h00);
      step(8'h00, 0, 8'h00, 0);

      // Reset in the middle of NOTCH1
      for (int i = 0; i < 5; i++) step(8'h01, 0, 8'h00, 0);
      check("mid_cam", cam, 8'hFE);
      reset = 1'b1;
      step(8'h00, 0, 8'h00, 0);
      reset = 1'b0;
      check("midrst_cam", cam, 8'hFF);
      check("midrst_total", vend_total, 16'd0);
      check("midrst_stock0", dut.g_col[0].u_col.stock, 4'd5);
      check("midrst_stock3", dut.g_col[3].u_col.stock, 4'd5);

      // Motor held through PARK gives a double vend
      for (int i = 0; i < 32; i++) step(8'h01, 0, 8'h00, 0);
      step(8'h00, 0, 8'h00, 0);
      check("double_total", vend_total, 16'd2);
      check("double_stock0", dut.g_col[0].u_col.stock, 4'd3);
      check("double_cam", cam, 8'hFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
